// File: rtl/req_encoder8_3.sv
// Sequential 8-to-3 request encoder: latches falling edges on eight active-low
// request lines and presents them one at a time, highest index first, over VALID/ACK.
module req_encoder8_3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_n,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [3:0] pend_cnt,
  output logic       ovr
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    req_d;
  logic [N_REQ-1:0]    pend, pend_nxt;
  logic [N_REQ-1:0]    rise, clr;
  logic [CODE_W-1:0]   code_nxt;
  logic                valid_nxt;
  logic [CNT_W-1:0]    pend_cnt_nxt;
  logic                ovr_nxt;

  function automatic logic [CODE_W-1:0] hi_idx(input logic [N_REQ-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // State and output registers; req_d resets high so a line held low at release counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_d    <= '1;
      pend     <= '0;
      code     <= '0;
      valid    <= 1'b0;
      pend_cnt <= '0;
      ovr      <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_d    <= req_n;
      pend     <= pend_nxt;
      code     <= code_nxt;
      valid    <= valid_nxt;
      pend_cnt <= pend_cnt_nxt;
      ovr      <= ovr_nxt;
    end
  end

  // Edge capture, acknowledge clear (a new edge wins over the clear) and handshake FSM.
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    valid_nxt = valid;
    clr       = '0;

    rise = req_d & ~req_n;
    if (state == PRESENT && ack) clr = N_REQ'(1) << code;

    pend_nxt     = (pend & ~clr) | rise;
    ovr_nxt      = |(rise & pend & ~clr);
    pend_cnt_nxt = popcount(pend_nxt);

    case (state)
      IDLE: begin
        if (|pend) begin
          code_nxt  = hi_idx(pend);
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_req_encoder8_3.sv
// Self-checking bench for req_encoder8_3: expected presentations are queued when
// requests are driven and popped when the encoder raises valid.
module tb_req_encoder8_3;

  typedef struct {
    logic [2:0] code;
    logic [3:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_n;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [3:0] pend_cnt;
  logic       ovr;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  req_encoder8_3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_n    (req_n),
    .ack      (ack),
    .code     (code),
    .valid    (valid),
    .pend_cnt (pend_cnt),
    .ovr      (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_n = 8'hFF;
    ack   = 1'b0;
    step();
    step();
    n_tests++;
    if ({code, valid, pend_cnt, ovr} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: code=%0d valid=%0b cnt=%0d ovr=%0b, required all 0",
               code, valid, pend_cnt, ovr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    exp_t e;
    req_n = 8'hF7;
    exp_q.push_back('{code: 3'd3, cnt: 4'd1});
    step();
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL single_capture: valid=%0b cnt=%0d, required valid=0 cnt=1", valid, pend_cnt);
    end
    step();
    e = exp_q.pop_front();
    n_tests++;
    if (valid !== 1'b1 || code !== e.code || pend_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL single_present: valid=%0b code=%0d cnt=%0d, required valid=1 code=%0d cnt=%0d",
               valid, code, pend_cnt, e.code, e.cnt);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL single_ack: valid=%0b cnt=%0d, required valid=0 cnt=0", valid, pend_cnt);
    end
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL single_no_reraise: valid=%0b cnt=%0d, required valid=0 cnt=0", valid, pend_cnt);
    end
    req_n = 8'hFF;
    step();
  endtask

  task automatic test_drain();
    exp_t e;
    bit   prev_valid;
    int   cyc;
    req_n = 8'h5A;
    ack   = 1'b1;
    exp_q.push_back('{code: 3'd7, cnt: 4'd4});
    exp_q.push_back('{code: 3'd5, cnt: 4'd3});
    exp_q.push_back('{code: 3'd2, cnt: 4'd2});
    exp_q.push_back('{code: 3'd0, cnt: 4'd1});
    prev_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      step();
      cyc++;
      if (valid === 1'b1) begin
        e = exp_q.pop_front();
        n_tests++;
        if (code !== e.code || pend_cnt !== e.cnt || prev_valid) begin
          n_fail++;
          $display("FAIL drain_code: code=%0d cnt=%0d back_to_back=%0b, required code=%0d cnt=%0d gap",
                   code, pend_cnt, prev_valid, e.code, e.cnt);
        end
      end
      prev_valid = (valid === 1'b1);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d codes never presented, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%0b cnt=%0d, required valid=0 cnt=0", valid, pend_cnt);
    end
    ack   = 1'b0;
    req_n = 8'hFF;
    step();
  endtask

  task automatic test_no_preempt();
    exp_t e;
    req_n = 8'hFB;
    exp_q.push_back('{code: 3'd2, cnt: 4'd1});
    step();
    step();
    req_n = 8'hBB;
    exp_q.push_back('{code: 3'd6, cnt: 4'd1});
    for (int i = 0; i < 3; i++) step();
    e = exp_q.pop_front();
    n_tests++;
    if (valid !== 1'b1 || code !== e.code || pend_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL no_preempt_hold: valid=%0b code=%0d cnt=%0d, required valid=1 code=%0d cnt=2",
               valid, code, pend_cnt, e.code);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    e = exp_q.pop_front();
    n_tests++;
    if (valid !== 1'b1 || code !== e.code || pend_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL no_preempt_next: valid=%0b code=%0d cnt=%0d, required valid=1 code=%0d cnt=%0d",
               valid, code, pend_cnt, e.code, e.cnt);
    end
    ack = 1'b1;
    step();
    ack   = 1'b0;
    req_n = 8'hFF;
    step();
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL no_preempt_clear: valid=%0b cnt=%0d, required valid=0 cnt=0", valid, pend_cnt);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    req_n = 8'hEF;
    exp_q.push_back('{code: 3'd4, cnt: 4'd1});
    step();
    step();
    e = exp_q.pop_front();
    n_tests++;
    if (valid !== 1'b1 || code !== e.code || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_present: valid=%0b code=%0d ovr=%0b, required valid=1 code=%0d ovr=0",
               valid, code, ovr, e.code);
    end
    req_n = 8'hFF;
    step();
    req_n = 8'hEF;
    step();
    n_tests++;
    if (ovr !== 1'b1 || pend_cnt !== 4'd1 || code !== 3'd4) begin
      n_fail++;
      $display("FAIL ovr_pulse: ovr=%0b cnt=%0d code=%0d, required ovr=1 cnt=1 code=4",
               ovr, pend_cnt, code);
    end
    step();
    n_tests++;
    if (ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: ovr=%0b, required 0", ovr);
    end
    ack = 1'b1;
    step();
    step();
    ack = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_single_ack: valid=%0b cnt=%0d ovr=%0b, required valid=0 cnt=0 ovr=0",
               valid, pend_cnt, ovr);
    end
    req_n = 8'hFF;
    step();
  endtask

  task automatic test_ack_collide();
    exp_t e;
    req_n = 8'hFD;
    exp_q.push_back('{code: 3'd1, cnt: 4'd1});
    exp_q.push_back('{code: 3'd1, cnt: 4'd1});
    step();
    step();
    e = exp_q.pop_front();
    n_tests++;
    if (valid !== 1'b1 || code !== e.code) begin
      n_fail++;
      $display("FAIL collide_first: valid=%0b code=%0d, required valid=1 code=%0d", valid, code, e.code);
    end
    req_n = 8'hFF;
    step();
    req_n = 8'hFD;
    ack   = 1'b1;
    step();
    ack = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd1 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_set_wins: valid=%0b cnt=%0d ovr=%0b, required valid=0 cnt=1 ovr=0",
               valid, pend_cnt, ovr);
    end
    step();
    e = exp_q.pop_front();
    n_tests++;
    if (valid !== 1'b1 || code !== e.code || pend_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL collide_represent: valid=%0b code=%0d cnt=%0d, required valid=1 code=%0d cnt=%0d",
               valid, code, pend_cnt, e.code, e.cnt);
    end
    ack = 1'b1;
    step();
    ack   = 1'b0;
    req_n = 8'hFF;
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    req_n = 8'h75;
    step();
    step();
    n_tests++;
    if (valid !== 1'b1 || code !== 3'd7 || pend_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL midrst_setup: valid=%0b code=%0d cnt=%0d, required valid=1 code=7 cnt=3",
               valid, code, pend_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({code, valid, pend_cnt, ovr} !== 9'd0) begin
      n_fail++;
      $display("FAIL midrst_async: code=%0d valid=%0b cnt=%0d ovr=%0b, required all 0",
               code, valid, pend_cnt, ovr);
    end
    req_n = 8'hFE;
    exp_q.push_back('{code: 3'd0, cnt: 4'd1});
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (valid !== 1'b0 || pend_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL midrst_capture: valid=%0b cnt=%0d, required valid=0 cnt=1", valid, pend_cnt);
    end
    step();
    e = exp_q.pop_front();
    n_tests++;
    if (valid !== 1'b1 || code !== e.code || pend_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL midrst_present: valid=%0b code=%0d cnt=%0d, required valid=1 code=%0d cnt=%0d",
               valid, code, pend_cnt, e.code, e.cnt);
    end
    ack = 1'b1;
    step();
    ack   = 1'b0;
    req_n = 8'hFF;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_drain();
    test_no_preempt();
    test_overrun();
    test_ack_collide();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
